// File: rtl/ram_sync.sv
// Single-clock word RAM with NUM_RD registered read ports, one byte-masked write port,
// and a post-reset sweep that zeroes every word before normal operation starts.
`timescale 1ns/1ps
module ram_sync #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 65536,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       busy,
    input  logic [NUM_RD-1:0]          rd_req,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD-1:0]          rd_valid,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_err,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    output logic                       wr_err
);
    // Handshake: a request is accepted on any rising edge where rd_req[i] (or wr_en) is
    // high and busy is low; no backpressure. rd_valid[i] pulses for one cycle after it.
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_in;
    logic                wr_ok;
    logic [IDX_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   wr_merged;
    logic [ADDR_W-1:0]   rd_a    [NUM_RD];
    logic [NUM_RD-1:0]   rd_ok;
    logic [DATA_W-1:0]   rd_word [NUM_RD];

    assign busy   = (state == CLEAR);
    // Range checks use the full address plus a guard bit so DEPTH == 2**ADDR_W still works.
    assign wr_in  = ({1'b0, wr_addr} < DEPTH_X);
    assign wr_ok  = (state == IDLE) && wr_en && wr_in;
    assign wr_idx = wr_addr[IDX_W-1:0];

    always_comb begin
        wr_merged = mem[wr_idx];
        for (int k = 0; k < NB; k++) begin
            if (wr_be[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
        end
    end

    // Write-first: a same-cycle hit returns the merged word being written.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_a[i]  = rd_addr[i*ADDR_W +: ADDR_W];
            rd_ok[i] = ({1'b0, rd_a[i]} < DEPTH_X);
            if (!rd_ok[i])
                rd_word[i] = '0;
            else if (wr_ok && (rd_a[i] == wr_addr))
                rd_word[i] = wr_merged;
            else
                rd_word[i] = mem[rd_a[i][IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == LAST) state <= IDLE;
                    else                 clr_cnt <= clr_cnt + ADDR_W'(1);
                end
                IDLE: state <= IDLE;
                default: state <= CLEAR;
            endcase
        end
    end

    // Array storage has no reset; only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt[IDX_W-1:0]] <= '0;
            end else if (wr_ok) begin
                for (int k = 0; k < NB; k++) begin
                    if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= '0;
            rd_err   <= '0;
            rd_data  <= '0;
            wr_err   <= 1'b0;
        end else begin
            wr_err <= (state == IDLE) && wr_en && !wr_in;
            for (int i = 0; i < NUM_RD; i++) begin
                rd_valid[i] <= (state == IDLE) && rd_req[i];
                if ((state == IDLE) && rd_req[i]) begin
                    rd_data[i*DATA_W +: DATA_W] <= rd_word[i];
                    rd_err[i]                   <= !rd_ok[i];
                end else begin
                    rd_err[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_sync.sv
// Directed bench for ram_sync (DEPTH=16): driver tasks push expected read/wr_err
// responses into queues; a negedge monitor pops and compares as the DUT responds.
`timescale 1ns/1ps
module tb_ram_sync;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NR  = 2;
    localparam int DEP = 16;
    localparam int W   = 49;  // {due_cycle[15:0], err, data[31:0]}

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              busy;
    logic [NR-1:0]     rd_req = '0;
    logic [NR*AW-1:0]  rd_addr = '0;
    logic [NR-1:0]     rd_valid;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_err;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic [DW/8-1:0]   wr_be = '0;
    logic              wr_err;

    ram_sync #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .NUM_RD(NR)) dut (
        .clk(clk), .rst(rst), .busy(busy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_err(rd_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_err(wr_err)
    );

    // clock / reset-free cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [15:0]  werr_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        tick();
        rd_req = '0;
        wr_en  = 1'b0;
        wr_be  = '0;
    endtask

    task automatic issue_rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
        logic [W-1:0] item;
        item = {16'(cyc + 1), e, d};
        rd_req[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
        if (p == 0) exp_q0.push_back(item);
        else        exp_q1.push_back(item);
    endtask

    task automatic issue_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        if (int'(a) >= DEP) werr_q.push_back(16'(cyc + 1));
    endtask

    // Counts rising edges with busy high; drives ignored traffic while it waits.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            rd_req = 2'b11;
            rd_addr = {5'd20, 5'd5};
            wr_en = 1'b1; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
            wr_addr = n[0] ? 5'd20 : 5'd5;
            tick();
            n++;
        end
        rd_req = '0; wr_en = 1'b0; wr_be = '0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid[0]) begin
                if (exp_q0.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rd0_unexpected: got rd_valid at cycle %0d, required none", cyc);
                end else
                    check("rd0", {15'b0, cyc[15:0], rd_err[0], rd_data[31:0]}, {15'b0, exp_q0.pop_front()});
            end
            if (rd_valid[1]) begin
                if (exp_q1.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rd1_unexpected: got rd_valid at cycle %0d, required none", cyc);
                end else
                    check("rd1", {15'b0, cyc[15:0], rd_err[1], rd_data[63:32]}, {15'b0, exp_q1.pop_front()});
            end
            if (wr_err) begin
                if (werr_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL wr_err_unexpected: got pulse at cycle %0d, required none", cyc);
                end else
                    check("wr_err_cycle", {48'b0, cyc[15:0]}, {48'b0, werr_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        #1 rst = 1'b1;
        tick(); tick();
        check("rst_busy", busy, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wr_err", wr_err, 0);
        rst = 1'b0;
        count_busy(n);
        check("busy_edges_1", n, 16);

        // every word is zero after the sweep, including word 5 written while busy
        for (int k = 0; k < 8; k++) begin
            issue_rd(0, 5'(2*k), 32'h0, 1'b0);
            issue_rd(1, 5'(2*k+1), 32'h0, 1'b0);
            cycle();
        end

        // byte lanes, back-to-back reads, hold after read
        issue_wr(5'd3, 32'hDEAD_BEEF, 4'hF); cycle();
        issue_wr(5'd3, 32'h1122_3344, 4'h5); cycle();
        issue_rd(0, 5'd3, 32'hDE22_BE44, 1'b0); cycle();
        issue_rd(0, 5'd3, 32'hDE22_BE44, 1'b0); cycle();
        cycle(); cycle();
        check("rd0_hold", rd_data[31:0], 32'hDE22_BE44);

        // write-first on a same-cycle hit
        issue_wr(5'd7, 32'hAAAA_AAAA, 4'hF); cycle();
        issue_wr(5'd7, 32'h5555_5555, 4'h3);
        issue_rd(1, 5'd7, 32'hAAAA_5555, 1'b0); cycle();
        issue_rd(0, 5'd7, 32'hAAAA_5555, 1'b0);
        issue_rd(1, 5'd3, 32'hDE22_BE44, 1'b0); cycle();
        issue_rd(0, 5'd3, 32'hDE22_BE44, 1'b0);
        issue_rd(1, 5'd3, 32'hDE22_BE44, 1'b0); cycle();

        // zero byte enables change nothing
        issue_wr(5'd3, 32'h0, 4'h0); cycle();
        issue_rd(0, 5'd3, 32'hDE22_BE44, 1'b0); cycle();

        // out-of-range accesses, no aliasing of the high address bit
        issue_rd(0, 5'd20, 32'h0, 1'b1);
        issue_rd(1, 5'd15, 32'h0, 1'b0); cycle();
        issue_wr(5'd16, 32'hFFFF_FFFF, 4'hF); cycle();
        issue_rd(0, 5'd0, 32'h0, 1'b0);
        issue_rd(1, 5'd31, 32'h0, 1'b1); cycle();
        issue_wr(5'd19, 32'h0BAD_F00D, 4'hF);
        issue_rd(0, 5'd19, 32'h0, 1'b1); cycle();
        issue_wr(5'd15, 32'h1234_5678, 4'hF); cycle();
        issue_rd(1, 5'd15, 32'h1234_5678, 1'b0);
        issue_rd(0, 5'd3, 32'hDE22_BE44, 1'b0); cycle();

        // reset in the middle of the sweep restarts it from word 0
        issue_wr(5'd12, 32'h0000_0001, 4'hF); cycle();
        issue_rd(0, 5'd12, 32'h0000_0001, 1'b0); cycle();
        cycle();
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (9) tick();
        check("sweep_busy_at_9", busy, 1);
        rst = 1'b1; #1;
        check("midsweep_rst_busy", busy, 1);
        check("midsweep_rst_rd_data", rd_data, 0);
        tick(); tick();
        rst = 1'b0;
        count_busy(n);
        check("busy_edges_2", n, 16);
        issue_rd(0, 5'd12, 32'h0, 1'b0);
        issue_rd(1, 5'd7, 32'h0, 1'b0); cycle();
        issue_rd(0, 5'd3, 32'h0, 1'b0);
        issue_rd(1, 5'd15, 32'h0, 1'b0); cycle();
        cycle(); cycle();

        check("exp_q0_drained", exp_q0.size(), 0);
        check("exp_q1_drained", exp_q1.size(), 0);
        check("werr_q_drained", werr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_sync.md
RAM_SYNC -- requirements
Module: ram_sync

Interface
REQ-001 SHALL: ADDR_W, default 16, word-address width.
REQ-002 SHALL: DATA_W, default 32, word width; multiple of 8; byte lanes NB = DATA_W/8.
REQ-003 SHALL: DEPTH, default 65536, number of words; 2 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL: NUM_RD, default 2, number of independent read ports.
REQ-005 SHALL: clk  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL: rst  in  1  reset; asynchronous, active-high.
REQ-007 SHALL: busy  out  1  high while the post-reset clear sweep runs.
REQ-008 SHALL: rd_req  in  NUM_RD  per-port read request.
REQ-009 SHALL: rd_addr  in  NUM_RD*ADDR_W  per-port word address; port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL: rd_valid  out  NUM_RD  per-port one-cycle read-data-valid pulse.
REQ-011 SHALL: rd_data  out  NUM_RD*DATA_W  per-port registered read data; port i at [i*DATA_W +: DATA_W].
REQ-012 SHALL: rd_err  out  NUM_RD  per-port out-of-range flag, qualified by rd_valid.
REQ-013 SHALL: wr_en  in  1  write request.
REQ-014 SHALL: wr_addr  in  ADDR_W  write word address.
REQ-015 SHALL: wr_data  in  DATA_W  write data.
REQ-016 SHALL: wr_be  in  NB  byte enables; bit k covers wr_data[8k+7:8k].
REQ-017 SHALL: wr_err  out  1  one-cycle pulse for a rejected out-of-range write.

Function
REQ-018 SHALL: FSM with two states, CLEAR and IDLE; busy = 1 exactly in CLEAR.
REQ-019 SHALL: in CLEAR, write zero to word clr_cnt each cycle, clr_cnt from 0 to DEPTH-1; after writing DEPTH-1, move to IDLE.
REQ-020 SHALL: busy high for exactly DEPTH rising edges after rst deasserts; first IDLE cycle follows.
REQ-021 SHALL: in CLEAR, ignore rd_req and wr_en; no rd_valid, rd_err, wr_err, or memory change from them.
REQ-022 SHALL: in IDLE, rd_req[i]=1 at edge N gives rd_valid[i]=1 after edge N+1 (latency 1); each port independent; all ports may hit one address.
REQ-023 SHALL: rd_valid[i] is a single-cycle pulse per accepted request; back-to-back requests give back-to-back pulses.
REQ-024 SHALL: rd_data[i] holds its last value until the next accepted read on port i.
REQ-025 SHALL: in IDLE, a write with wr_addr < DEPTH updates only the lanes whose wr_be bit is set; wr_be = 0 changes nothing and raises no error.
REQ-026 SHALL: same-cycle read and write to one in-range address is write-first: rd_data = old word with enabled lanes replaced by wr_data.
REQ-027 SHALL: address >= DEPTH on read gives rd_data = 0 and rd_err = 1 alongside rd_valid; memory untouched.
REQ-028 SHALL: wr_addr >= DEPTH with wr_en = 1 is dropped and wr_err pulses for one cycle after the edge.
REQ-029 SHALL: every comparison and index uses full ADDR_W bits; no truncation or aliasing of high address bits.

Reset
REQ-030 SHALL: rst = 1 forces immediately: state CLEAR, clr_cnt = 0, busy = 1, rd_valid = 0, rd_err = 0, rd_data = 0, wr_err = 0.
REQ-031 SHALL: rst asserted mid-sweep or mid-operation aborts the current work; the sweep restarts from word 0 after release.
REQ-032 SHALL: memory contents are not reset asynchronously; only the sweep zeroes them.

Verification (DEPTH=16, ADDR_W=5, DATA_W=32, NUM_RD=2)
REQ-033 SHALL: release rst -> busy=1 for exactly 16 edges, then 0; read of every word 0..15 returns 0x00000000.
REQ-034 SHALL: write 0xDEADBEEF to 3 with be=0xF, then write 0x11223344 to 3 with be=0x5 -> port 0 read of 3 returns 0xDE22BE44, rd_valid one cycle after rd_req.
REQ-035 SHALL: with word 7 = 0xAAAAAAAA, same cycle write 0x55555555 be=0x3 to 7 plus port 1 read of 7 -> rd_data[1] = 0xAAAA5555.
REQ-036 SHALL: port 0 read of 20 -> rd_valid[0]=1, rd_err[0]=1, rd_data[0]=0; write to 16 -> wr_err pulses once and word 0 is unchanged.
REQ-037 SHALL: assert rst at sweep cycle 9 after a prior write of 0x1 to word 12 -> busy restarts, stays high 16 edges after release, word 12 reads 0.
REQ-038 SHALL: rd_req or wr_en asserted during busy -> no rd_valid, no wr_err; contents stay 0 after the sweep.
